// File: rtl/countdown_sequencer.sv
// rtl/countdown_sequencer.sv - MM:SS countdown control FSM: button press detect, set/run/pause/done walk, clamped loads, alarm timing
module countdown_sequencer #(
  parameter int ALARM_TICKS = 10,
  parameter bit CLAMP_EN    = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       set,
  input  logic [3:0] sw_tens,
  input  logic [3:0] sw_ones,
  input  logic       tick,
  input  logic       zero,
  output logic       load_sec,
  output logic       load_min,
  output logic [3:0] load_tens,
  output logic [3:0] load_ones,
  output logic       count_en,
  output logic       blink,
  output logic       alarm,
  output logic [2:0] state
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SET_SEC = 3'd1;
  localparam logic [2:0] S_SET_MIN = 3'd2;
  localparam logic [2:0] S_PAUSE   = 3'd3;
  localparam logic [2:0] S_RUN     = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;
  localparam logic [7:0] ALARM_MAX = 8'(ALARM_TICKS);

  logic [2:0] r_state;
  logic       r_ss_q, r_set_q;
  logic       r_ss_blk, r_set_blk;
  logic       r_load_sec, r_load_min;
  logic [3:0] r_load_tens, r_load_ones;
  logic       r_count_en, r_blink, r_alarm;
  logic [7:0] r_cnt;

  logic       w_ss_press, w_set_press;
  logic [2:0] w_next;
  logic [7:0] w_cnt_inc;
  logic       w_alarm_done;
  logic [3:0] w_sec_tens, w_min_tens, w_ones;
  logic       w_next_is_set;

  // A button held through reset stays blocked until it is released once.
  assign w_ss_press  = start_stop & ~r_ss_q & ~r_ss_blk;
  assign w_set_press = set & ~r_set_q & ~r_set_blk;

  assign w_sec_tens = (CLAMP_EN && sw_tens > 4'd5) ? 4'd5 : sw_tens;
  assign w_min_tens = (CLAMP_EN && sw_tens > 4'd9) ? 4'd9 : sw_tens;
  assign w_ones     = (CLAMP_EN && sw_ones > 4'd9) ? 4'd9 : sw_ones;

  assign w_cnt_inc    = (tick && r_cnt != ALARM_MAX) ? r_cnt + 8'd1 : r_cnt;
  assign w_alarm_done = (w_cnt_inc == ALARM_MAX);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_set_press) w_next = S_SET_SEC;
      S_SET_SEC: if (w_set_press) w_next = S_SET_MIN;
      S_SET_MIN: if (w_set_press) w_next = S_PAUSE;
      S_PAUSE: begin
        if (w_ss_press) begin
          if (!zero) w_next = S_RUN;
        end else if (w_set_press) begin
          w_next = S_SET_SEC;
        end
      end
      S_RUN: begin
        if (w_ss_press)  w_next = S_PAUSE;
        else if (zero)   w_next = S_DONE;
      end
      S_DONE:    if (w_ss_press || w_set_press || w_alarm_done) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  assign w_next_is_set = (w_next == S_SET_SEC) || (w_next == S_SET_MIN);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_ss_q      <= 1'b0;
      r_set_q     <= 1'b0;
      r_ss_blk    <= start_stop;
      r_set_blk   <= set;
      r_load_sec  <= 1'b0;
      r_load_min  <= 1'b0;
      r_load_tens <= 4'd0;
      r_load_ones <= 4'd0;
      r_count_en  <= 1'b0;
      r_blink     <= 1'b0;
      r_alarm     <= 1'b0;
      r_cnt       <= 8'd0;
    end else begin
      r_state    <= w_next;
      r_ss_q     <= start_stop;
      r_set_q    <= set;
      r_ss_blk   <= r_ss_blk & start_stop;
      r_set_blk  <= r_set_blk & set;
      r_load_sec <= (r_state == S_SET_SEC) && w_set_press;
      r_load_min <= (r_state == S_SET_MIN) && w_set_press;
      if ((r_state == S_SET_SEC) && w_set_press) begin
        r_load_tens <= w_sec_tens;
        r_load_ones <= w_ones;
      end else if ((r_state == S_SET_MIN) && w_set_press) begin
        r_load_tens <= w_min_tens;
        r_load_ones <= w_ones;
      end else begin
        r_load_tens <= 4'd0;
        r_load_ones <= 4'd0;
      end
      r_count_en <= (w_next == S_RUN);
      r_alarm    <= (w_next == S_DONE);
      if (r_state != S_DONE)
        r_cnt <= 8'd0;
      else
        r_cnt <= w_cnt_inc;
      // Blink restarts from 0 on every entry into an edit state.
      if (w_next_is_set && (w_next == r_state))
        r_blink <= r_blink ^ tick;
      else
        r_blink <= 1'b0;
    end
  end

  assign state     = r_state;
  assign load_sec  = r_load_sec;
  assign load_min  = r_load_min;
  assign load_tens = r_load_tens;
  assign load_ones = r_load_ones;
  assign count_en  = r_count_en;
  assign blink     = r_blink;
  assign alarm     = r_alarm;

endmodule

// File: tb/tb_countdown_sequencer.sv
// tb/tb_countdown_sequencer.sv - directed and random checks of countdown_sequencer against a behavioural model
module tb_countdown_sequencer;
  localparam int AT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn, ss, st, tk, zr;
  logic [3:0] swt, swo;
  logic       load_sec, load_min, count_en, blink, alarm;
  logic [3:0] load_tens, load_ones;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;

  countdown_sequencer #(.ALARM_TICKS(AT), .CLAMP_EN(1'b1)) dut (
    .clk(clk), .reset(rstn), .start_stop(ss), .set(st),
    .sw_tens(swt), .sw_ones(swo), .tick(tk), .zero(zr),
    .load_sec(load_sec), .load_min(load_min),
    .load_tens(load_tens), .load_ones(load_ones),
    .count_en(count_en), .blink(blink), .alarm(alarm), .state(state)
  );

  // Behavioural model: mode number, button "armed" flags, alarm tick tally.
  int m_state = 0, m_cnt = 0, m_lt = 0, m_lo = 0;
  bit m_prev_ss = 0, m_prev_st = 0, m_hold_ss = 0, m_hold_st = 0;
  bit m_blink = 0, m_ls = 0, m_lm = 0, m_ce = 0, m_al = 0;

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit pss, pst;
    int ns;
    if (!rstn) begin
      m_state = 0; m_cnt = 0; m_lt = 0; m_lo = 0;
      m_prev_ss = 0; m_prev_st = 0; m_hold_ss = ss; m_hold_st = st;
      m_blink = 0; m_ls = 0; m_lm = 0; m_ce = 0; m_al = 0;
    end else begin
      pss = ss && !m_prev_ss && !m_hold_ss;
      pst = st && !m_prev_st && !m_hold_st;
      ns = m_state;
      if (m_state <= 2) begin
        if (pst) ns = m_state + 1;
      end else if (m_state == 3) begin
        if (pss) ns = zr ? 3 : 4;
        else if (pst) ns = 1;
      end else if (m_state == 4) begin
        if (pss) ns = 3;
        else if (zr) ns = 5;
      end else if (m_state == 5) begin
        if (pss || pst || (m_cnt + int'(tk)) >= AT) ns = 0;
      end else begin
        ns = 0;
      end
      m_ls = (m_state == 1) && pst;
      m_lm = (m_state == 2) && pst;
      m_lt = m_ls ? imin(int'(swt), 5) : (m_lm ? imin(int'(swt), 9) : 0);
      m_lo = (m_ls || m_lm) ? imin(int'(swo), 9) : 0;
      m_cnt = (m_state == 5) ? imin(m_cnt + int'(tk), AT) : 0;
      m_blink = (ns == m_state && (ns == 1 || ns == 2)) ? (m_blink ^ tk) : 1'b0;
      m_ce = (ns == 4);
      m_al = (ns == 5);
      m_prev_ss = ss; m_prev_st = st;
      m_hold_ss = m_hold_ss & ss; m_hold_st = m_hold_st & st;
      m_state = ns;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_step();
    chk("m_state", 32'(state), 32'(m_state));
    chk("m_count_en", 32'(count_en), 32'(m_ce));
    chk("m_alarm", 32'(alarm), 32'(m_al));
    chk("m_blink", 32'(blink), 32'(m_blink));
    chk("m_load_sec", 32'(load_sec), 32'(m_ls));
    chk("m_load_min", 32'(load_min), 32'(m_lm));
    chk("m_load_tens", (m_ls || m_lm) ? 32'(load_tens) : 32'd0, 32'(m_lt));
    chk("m_load_ones", (m_ls || m_lm) ? 32'(load_ones) : 32'd0, 32'(m_lo));
  endtask

  task automatic press_set();
    st = 1; step(); st = 0;
  endtask

  initial begin
    rstn = 0; ss = 0; st = 1; tk = 0; zr = 0; swt = 0; swo = 0;
    repeat (3) step();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_outs", 32'({load_sec, load_min, load_tens, load_ones, count_en, blink, alarm}), 32'd0);
    rstn = 1; step();
    chk("held_set_no_press", 32'(state), 32'd0);
    step();
    chk("held_set_still_idle", 32'(state), 32'd0);
    st = 0; step();
    press_set();
    chk("idle_to_set_sec", 32'(state), 32'd1);
    step();
    swt = 7; swo = 12; press_set();
    chk("set_sec_to_min", 32'(state), 32'd2);
    chk("load_sec_pulse", 32'({load_sec, load_tens, load_ones}), 32'h159);
    step();
    chk("load_sec_one_cycle", 32'(load_sec), 32'd0);
    swt = 3; swo = 4; press_set();
    chk("set_min_to_pause", 32'(state), 32'd3);
    chk("load_min_pulse", 32'({load_min, load_tens, load_ones}), 32'h134);
    step();
    chk("load_min_one_cycle", 32'(load_min), 32'd0);
    ss = 1; step(); ss = 0;
    chk("pause_to_run", 32'({state, count_en}), 32'({3'd4, 1'b1}));
    step();
    ss = 1; step(); ss = 0;
    chk("run_to_pause", 32'({state, count_en}), 32'({3'd3, 1'b0}));
    zr = 1; step();
    ss = 1; step(); ss = 0;
    chk("pause_zero_ignored", 32'(state), 32'd3);
    zr = 0; step();
    ss = 1; step(); ss = 0;
    step();
    zr = 1; step();
    chk("run_to_done", 32'({state, count_en, alarm}), 32'({3'd5, 1'b0, 1'b1}));
    tk = 1; step(); tk = 0; step();
    tk = 1; step(); tk = 0; step();
    chk("done_after_two_ticks", 32'({state, alarm}), 32'({3'd5, 1'b1}));
    tk = 1; step(); tk = 0;
    chk("done_to_idle", 32'({state, alarm}), 32'({3'd0, 1'b0}));
    zr = 0; step();
    press_set(); step(); press_set(); step();
    ss = 1; st = 1; step(); ss = 0; st = 0;
    chk("both_in_set_min", 32'({state, load_min}), 32'({3'd3, 1'b1}));
    step();
    ss = 1; step(); ss = 0; step();
    ss = 1; st = 1; step(); ss = 0; st = 0;
    chk("both_in_run", 32'({state, load_sec, load_min}), 32'({3'd3, 2'b00}));
    step();
    press_set();
    chk("pause_reedit", 32'({state, blink}), 32'({3'd1, 1'b0}));
    for (int i = 0; i < 4; i++) begin
      step();
      tk = 1; step(); tk = 0;
      chk("blink_seq", 32'(blink), 32'(i % 2 == 0));
    end
    step();
    press_set();
    chk("blink_clear_set_min", 32'({state, blink}), 32'({3'd2, 1'b0}));
    press_set(); step();
    ss = 1; step(); ss = 0;
    rstn = 0; ss = 1; step();
    chk("reset_mid_run", 32'({state, count_en}), 32'd0);
    rstn = 1; ss = 0; step();

    for (int i = 0; i < 3000; i++) begin
      rstn = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 5) == 0) ss = ~ss;
      if ($urandom_range(0, 4) == 0) st = ~st;
      tk  = ($urandom_range(0, 3) == 0);
      zr  = ($urandom_range(0, 7) == 0);
      swt = 4'($urandom);
      swo = 4'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
